hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Central pipeline hazard controller for the 5-stage MIPS core. Drives the stall, flush and forward controls
//  that cpu currently ties off: stallf, FlushE, ForwardAE/BE. Detects load-use and branch-operand hazards and
//  selects forwarding paths. Freezes the whole pipeline while the data memory raises mem_busy (multi-cycle
//  access handshake). Traps stuck accesses in a sticky error state.
// PARAMETERS
//  REG_ADDR_W   5   register-id width
//  MEM_TIMEOUT  16  max consecutive mem_busy cycles before error (>=1)
//  CNT_W        32  performance-counter width (used only with HAZ_PERF_CNT_EN)
// PORTS
//  clock       in   1           pipeline clock, rising edge
//  reset_n     in   1           asynchronous, active-low reset
//  RsD, RtD    in   REG_ADDR_W  source ids in decode
//  RsE, RtE    in   REG_ADDR_W  source ids in execute
//  WriteRegE/M/W in REG_ADDR_W  destination ids per stage
//  RegWriteE/M/W in 1           destination write enables per stage
//  MemtoRegE/M in   1           stage holds a load
//  BranchD     in   1           decode holds a branch/jump needing register compare
//  mem_busy    in   1           data memory not ready; hold M
//  StallF, StallD, StallE, StallM out 1  hold corresponding pipeline register (active-high)
//  FlushD      out  1           clear IF/ID register (active-high)
//  FlushE      out  1           ACTIVE-LOW: 0 = insert bubble into ID/EX, 1 = normal
//  ForwardAE/BE out 2           00 regfile, 01 ResultW, 10 ALUOutM
//  ForwardAD/BD out 1           branch compare operand taken from ALUOutM
//  mem_timeout_err out 1        sticky; set on timeout
//  stall_cnt, flush_cnt out CNT_W  perf counters (macro only)
// BEHAVIOUR
//  FSM (registered): RUN, MEM_WAIT, ERROR. Reset -> RUN, timeout counter 0, err 0, counters 0.
//  Forwarding: combinational, all states. For src X in {RsE,RtE}: X!=0 & RegWriteM & WriteRegM==X -> 10.
//   Else X!=0 & RegWriteW & WriteRegW==X -> 01. Else 00. M beats W. Reg 0 never forwarded.
//   ForwardAD = RsD!=0 & RegWriteM & WriteRegM==RsD; ForwardBD likewise with RtD.
//  lwstall = MemtoRegE & (WriteRegE==RsD | WriteRegE==RtD) & WriteRegE!=0.
//  brstall = BranchD & ((RegWriteE & WriteRegE!=0 & WriteRegE in {RsD,RtD}) |
//   (MemtoRegM & WriteRegM!=0 & WriteRegM in {RsD,RtD})).
//  RUN state:
//   - mem_busy=0: StallF=StallD=lwstall|brstall; FlushE=~(lwstall|brstall); StallE=StallM=0.
//     FlushD=BranchD & ~StallD (taken branch kills fetched instr).
//   - mem_busy=1: StallF=StallD=StallE=StallM=1, FlushE=1, FlushD=0; next MEM_WAIT, timer<=1.
//     mem_busy has priority over lwstall/brstall; these are re-evaluated once the freeze ends.
//  MEM_WAIT state:
//   - Outputs identical to the RUN/mem_busy case while mem_busy=1; timer increments.
//   - mem_busy=0: outputs as in RUN that cycle; next RUN, timer<=0.
//   - timer==MEM_TIMEOUT & mem_busy: next ERROR, err<=1.
//  ERROR state: all stalls 1, FlushE=1, FlushD=0, mem_timeout_err=1; exit only via reset_n.
//  Reset mid-access: asserting reset_n=0 forces RUN and clears outputs to no-stall immediately (async).
//   Forwards remain combinational.
//  No stall/flush output is registered: zero-cycle latency from inputs. Only state, timer and counters are flops.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined:
//   - stall_cnt += 1 each cycle StallF=1.
//   - flush_cnt += 1 each cycle FlushE=0 or FlushD=1.
//   - Both counters saturate at all-ones and reset to 0.
//  HAZ_PERF_CNT_EN undefined: counters not built; stall_cnt/flush_cnt tied to 0.
// STRUCTURE
//  Shared package hazard_defs.vh: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
//   state encodings HZ_RUN/HZ_MEM_WAIT/HZ_ERROR.
//  One sub-module hazard_fwd_sel: combinational forward select per operand,
//   instanced for A and B (E stage).
//  FSM, timer and perf counters live in the top of hazard_unit.
// TESTING
//  1. Load-use: MemtoRegE=1, WriteRegE=8, RsD=8 -> StallF=StallD=1, FlushE=0 for 1 cycle, then released.
//  2. Forward priority: RsE=5, WriteRegM=WriteRegW=5, both RegWrite=1 -> ForwardAE=10.
//     Repeat with RegWriteM=0 -> ForwardAE=01.
//  3. Reg 0: RtE=0, WriteRegM=0, RegWriteM=1 -> ForwardBE=00. Load with WriteRegE=0 -> no lwstall.
//  4. Branch: BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 -> brstall.
//     Next cycle data in M -> ForwardAD=1, FlushD=1.
//  5. mem_busy 3 cycles with lwstall pending -> all stalls 1, FlushE=1 for 3 cycles;
//     lwstall applies on 4th cycle.
//  6. mem_busy held >16 cycles -> mem_timeout_err=1 sticky. reset_n pulse -> RUN, err 0;
//     with HAZ_PERF_CNT_EN, stall_cnt counts then clears.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// ============================================================================
// Module      : hazard_unit_pkg
// Description : Shared constants for the pipeline hazard controller:
//               forwarding-select codes and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_unit_pkg;

  // Forwarding-select codes for the execute-stage ALU operand muxes
  localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from ResultW
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from ALUOutM

  // Hazard controller FSM encodings
  localparam int         HZ_STATE_W  = 2;
  localparam logic [1:0] HZ_RUN      = 2'd0;
  localparam logic [1:0] HZ_MEM_WAIT = 2'd1;
  localparam logic [1:0] HZ_ERROR    = 2'd2;

endpackage : hazard_unit_pkg

`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
// ============================================================================
// Module      : hazard_fwd_sel
// Description : Execute-stage forwarding select for one ALU source operand.
//               The memory stage wins over write-back because it holds the
//               younger result; register 0 is never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_fwd_sel
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] srcReg,
  input  logic [REG_ADDR_W-1:0] writeRegM,
  input  logic                  regWriteM,
  input  logic [REG_ADDR_W-1:0] writeRegW,
  input  logic                  regWriteW,
  output logic [1:0]            fwdSel
);

  logic w_srcValid;

  assign w_srcValid = (srcReg != '0);

  // Priority select: memory-stage result, then write-back result, else regfile
  always_comb begin
    fwdSel = FWD_REG;
    if (w_srcValid && regWriteM && (writeRegM == srcReg)) begin
      fwdSel = FWD_MEM;
    end else if (w_srcValid && regWriteW && (writeRegW == srcReg)) begin
      fwdSel = FWD_WB;
    end
  end

endmodule : hazard_fwd_sel

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module      : hazard_unit
// Description : Central hazard controller for the 5-stage pipeline. Detects
//               load-use and branch-operand hazards, selects forwarding
//               paths, freezes the pipeline while data memory is busy and
//               traps stuck memory accesses in a sticky error state.
//               Optional performance counters are built when the macro
//               HAZ_PERF_CNT_EN is defined; otherwise they read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RsE,
  input  logic [REG_ADDR_W-1:0] RtE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic [REG_ADDR_W-1:0] WriteRegW,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  MemtoRegM,
  input  logic                  BranchD,
  input  logic                  mem_busy,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  ForwardAD,
  output logic                  ForwardBD,
  output logic                  mem_timeout_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // Timer only needs to reach MEM_TIMEOUT; it never wraps
  localparam int                TMR_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  c_TIMEOUT = TMR_W'(MEM_TIMEOUT);
  localparam logic [TMR_W-1:0]  c_TMR_ONE = TMR_W'(1);

  logic [HZ_STATE_W-1:0] r_state;
  logic [HZ_STATE_W-1:0] w_nextState;
  logic [TMR_W-1:0]      r_timer;
  logic [TMR_W-1:0]      w_nextTimer;
  logic                  r_err;
  logic                  w_nextErr;

  logic w_lwStall;
  logic w_brStall;
  logic w_hazStall;
  logic w_freeze;

  // Ungated control values; the counters use these so that reset_n only
  // ever appears as an asynchronous reset on flops
  logic w_stallFD;
  logic w_stallEM;
  logic w_flushD;
  logic w_flushE;

  // --------------------------------------------------------------------------
  // Forwarding (combinational in every state)
  // --------------------------------------------------------------------------
  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwdA (
    .srcReg    (RsE),
    .writeRegM (WriteRegM),
    .regWriteM (RegWriteM),
    .writeRegW (WriteRegW),
    .regWriteW (RegWriteW),
    .fwdSel    (ForwardAE)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwdB (
    .srcReg    (RtE),
    .writeRegM (WriteRegM),
    .regWriteM (RegWriteM),
    .writeRegW (WriteRegW),
    .regWriteW (RegWriteW),
    .fwdSel    (ForwardBE)
  );

  assign ForwardAD = (RsD != '0) && RegWriteM && (WriteRegM == RsD);
  assign ForwardBD = (RtD != '0) && RegWriteM && (WriteRegM == RtD);

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  assign w_lwStall = MemtoRegE && (WriteRegE != '0) &&
                     ((WriteRegE == RsD) || (WriteRegE == RtD));

  // Branch compare happens in decode, so an E-stage ALU result or an M-stage
  // load feeding a branch operand cannot be forwarded in time
  assign w_brStall = BranchD &&
                     ((RegWriteE && (WriteRegE != '0) &&
                       ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                      (MemtoRegM && (WriteRegM != '0) &&
                       ((WriteRegM == RsD) || (WriteRegM == RtD))));

  assign w_hazStall = w_lwStall || w_brStall;

  // --------------------------------------------------------------------------
  // FSM: state, timeout timer and sticky error flag
  // --------------------------------------------------------------------------
  // State register with asynchronous reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= HZ_RUN;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_timer <= w_nextTimer;
      r_err   <= w_nextErr;
    end
  end

  // Next-state logic: count consecutive busy cycles, trap on timeout
  always_comb begin
    w_nextState = r_state;
    w_nextTimer = r_timer;
    w_nextErr   = r_err;
    case (r_state)
      HZ_RUN: begin
        if (mem_busy) begin
          w_nextState = HZ_MEM_WAIT;
          w_nextTimer = c_TMR_ONE;
        end
      end
      HZ_MEM_WAIT: begin
        if (!mem_busy) begin
          w_nextState = HZ_RUN;
          w_nextTimer = '0;
        end else if (r_timer == c_TIMEOUT) begin
          w_nextState = HZ_ERROR;
          w_nextErr   = 1'b1;
        end else begin
          w_nextTimer = r_timer + c_TMR_ONE;
        end
      end
      HZ_ERROR: begin
        w_nextState = HZ_ERROR;
      end
      default: begin
        w_nextState = HZ_RUN;
        w_nextTimer = '0;
      end
    endcase
  end

  // Output logic: busy memory or error freezes everything, else hazards apply
  always_comb begin
    w_freeze = 1'b0;
    case (r_state)
      HZ_RUN, HZ_MEM_WAIT: w_freeze = mem_busy;
      HZ_ERROR:            w_freeze = 1'b1;
      default:             w_freeze = 1'b0;
    endcase

    if (w_freeze) begin
      w_stallFD = 1'b1;
      w_stallEM = 1'b1;
      w_flushE  = 1'b1;
      w_flushD  = 1'b0;
    end else begin
      w_stallFD = w_hazStall;
      w_stallEM = 1'b0;
      w_flushE  = ~w_hazStall;
      w_flushD  = BranchD && !w_hazStall;
    end
  end

  // Reset asserted mid-access releases the pipeline immediately
  assign StallF          = reset_n && w_stallFD;
  assign StallD          = reset_n && w_stallFD;
  assign StallE          = reset_n && w_stallEM;
  assign StallM          = reset_n && w_stallEM;
  assign FlushD          = reset_n && w_flushD;
  assign FlushE          = !reset_n || w_flushE;
  assign mem_timeout_err = r_err;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  // Saturating event counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_stallFD && (r_stallCnt != '1)) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
      if ((!w_flushE || w_flushD) && (r_flushCnt != '1)) begin
        r_flushCnt <= r_flushCnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule : hazard_unit

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit. A reference model
//               derives the expected controls for each driven vector; the
//               expectation is queued and compared against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit;

  localparam int RW  = 5;
  localparam int TMO = 16;
  localparam int CW  = 32;

  typedef struct packed {
    logic       sF, sD, sE, sM, fD, fE;
    logic [1:0] aE, bE;
    logic       aD, bD, err;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [RW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic          BranchD, mem_busy;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          ForwardAD, ForwardBD, mem_timeout_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int   nChecks = 0;
  int   nErrors = 0;
  exp_t sbQ[$];

  // Model state
  int          mState;  // 0 run, 1 wait, 2 error
  int          mTimer;
  logic        mErr;
  logic [CW-1:0] mStallCnt, mFlushCnt;

  always #5 clock = ~clock;

  hazard_unit #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .mem_busy(mem_busy),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .mem_timeout_err(mem_timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fwdOf(input logic [RW-1:0] src);
    if (src == 0) return 2'b00;
    if (RegWriteM && WriteRegM == src) return 2'b10;
    if (RegWriteW && WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t modelOut();
    exp_t e;
    logic lw, br, hz;
    lw = MemtoRegE && (WriteRegE != 0) && (WriteRegE == RsD || WriteRegE == RtD);
    br = BranchD && ((RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                     (MemtoRegM && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD)));
    hz = lw || br;
    e.aE  = fwdOf(RsE);
    e.bE  = fwdOf(RtE);
    e.aD  = (RsD != 0) && RegWriteM && (WriteRegM == RsD);
    e.bD  = (RtD != 0) && RegWriteM && (WriteRegM == RtD);
    e.err = mErr;
    if (!reset_n) begin
      {e.sF, e.sD, e.sE, e.sM, e.fD, e.fE} = 6'b000001;
    end else if (mState == 2 || mem_busy) begin
      {e.sF, e.sD, e.sE, e.sM, e.fD, e.fE} = 6'b111101;
    end else begin
      e.sF = hz; e.sD = hz; e.sE = 1'b0; e.sM = 1'b0;
      e.fE = !hz;
      e.fD = BranchD && !hz;
    end
    return e;
  endfunction

  task automatic mReset();
    mState = 0; mTimer = 0; mErr = 1'b0; mStallCnt = '0; mFlushCnt = '0;
  endtask

  task automatic mAdvance(input exp_t e);
    if (e.sF && mStallCnt != '1) mStallCnt++;
    if ((!e.fE || e.fD) && mFlushCnt != '1) mFlushCnt++;
    case (mState)
      0: if (mem_busy) begin mState = 1; mTimer = 1; end
      1: begin
        if (!mem_busy) begin mState = 0; mTimer = 0; end
        else if (mTimer == TMO) begin mState = 2; mErr = 1'b1; end
        else mTimer++;
      end
      default: mState = 2;
    endcase
  endtask

  // Inputs are already applied; settle, check, then advance one clock
  task automatic step(input string tag);
    exp_t e, got;
    #1;
    if (!reset_n) mReset();
    sbQ.push_back(modelOut());
    got = {StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD, mem_timeout_err};
    e = sbQ.pop_front();
    checkEq({tag, ":ctl"}, 64'(got), 64'(e));
`ifdef HAZ_PERF_CNT_EN
    checkEq({tag, ":scnt"}, 64'(stall_cnt), 64'(mStallCnt));
    checkEq({tag, ":fcnt"}, 64'(flush_cnt), 64'(mFlushCnt));
`else
    checkEq({tag, ":scnt"}, 64'(stall_cnt), 64'd0);
    checkEq({tag, ":fcnt"}, 64'(flush_cnt), 64'd0);
`endif
    @(posedge clock);
    if (reset_n) mAdvance(e); else mReset();
    #1;
  endtask

  task automatic clearIn();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; mem_busy = 0;
  endtask

  initial begin
    mReset();
    reset_n = 1'b0;
    clearIn();
    step("reset");
    reset_n = 1'b1;
    step("idle");

    // Load-use stall, then release with the load now in M
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RsD = 8;
    step("lwstall");
    clearIn(); MemtoRegM = 1; RegWriteM = 1; WriteRegM = 8; RsE = 8; RsD = 8;
    step("lw_release");

    // Forward priority
    clearIn(); RsE = 5; WriteRegM = 5; WriteRegW = 5; RegWriteM = 1; RegWriteW = 1;
    step("fwd_m_wins");
    RegWriteM = 0;
    step("fwd_w");

    // Register zero
    clearIn(); RtE = 0; WriteRegM = 0; RegWriteM = 1;
    step("fwd_r0");
    clearIn(); MemtoRegE = 1; WriteRegE = 0; RsD = 0;
    step("lw_r0");

    // Branch hazards
    clearIn(); BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3;
    step("brstall_e");
    clearIn(); BranchD = 1; RsD = 3; RegWriteM = 1; WriteRegM = 3;
    step("br_fwd_ad");
    MemtoRegM = 1;
    step("brstall_m");
    clearIn(); BranchD = 1; RtD = 7; RegWriteM = 1; WriteRegM = 7;
    step("br_fwd_bd");

    // mem_busy holds priority over a pending load-use stall
    clearIn(); MemtoRegE = 1; RegWriteE = 1; WriteRegE = 9; RtD = 9;
    mem_busy = 1;
    for (int i = 0; i < 3; i++) step("busy_freeze");
    mem_busy = 0;
    step("busy_lw_after");

    // Random vectors over a small register set to provoke matches
    for (int i = 0; i < 60; i++) begin
      RsD = RW'($urandom_range(0, 3)); RtD = RW'($urandom_range(0, 3));
      RsE = RW'($urandom_range(0, 3)); RtE = RW'($urandom_range(0, 3));
      WriteRegE = RW'($urandom_range(0, 3)); WriteRegM = RW'($urandom_range(0, 3));
      WriteRegW = RW'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom); MemtoRegM = 1'($urandom); BranchD = 1'($urandom);
      mem_busy = ($urandom_range(0, 4) == 0);
      step("rand");
    end
    clearIn();
    step("settle");

    // Timeout: hold busy beyond the limit, error must be sticky
    mem_busy = 1;
    for (int i = 0; i < TMO + 3; i++) step("timeout");
    mem_busy = 0;
    step("err_hold");
    checkEq("err_sticky", 64'(mem_timeout_err), 64'd1);
    checkEq("err_stall", 64'(StallM), 64'd1);

    // Asynchronous reset in the middle of a cycle
    #2;
    mem_busy = 1;
    reset_n = 1'b0;
    step("rst_async");
    checkEq("rst_err", 64'(mem_timeout_err), 64'd0);
    reset_n = 1'b1;
    mem_busy = 0;
    MemtoRegE = 1; WriteRegE = 4; RsD = 4;
    step("post_rst_lw");
    clearIn();
    step("post_rst_idle");

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule : tb_hazard_unit

`default_nettype wire
